// File: rtl/l2_pkg.sv
// Shared definitions for the L2 tag/state controller.
// Holds the state encoding and the default index and tag widths.
package l2_pkg;

    localparam int L2_INDEX_W = 5;
    localparam int L2_TAG_W   = 21;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_LOOKUP   = 3'b001,
        S_ALLOCATE = 3'b011,
        S_RESP     = 3'b010,
        S_DRAIN    = 3'b110
    } state_t;

endpackage

// File: rtl/l2_tag_array.sv
// Tag, valid and LRU storage for a 2-way set-associative L2.
// Provides a combinational two-way compare, victim select and fill/LRU/flush write ports.
module l2_tag_array
    import l2_pkg::*;
#(
    parameter int INDEX_W = L2_INDEX_W,
    parameter int TAG_W   = L2_TAG_W
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [INDEX_W-1:0] idx,
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output logic               hit_way,
    output logic               victim_way,
    input  logic               fill_en,
    input  logic               fill_way,
    input  logic               lru_en,
    input  logic               lru_val,
    input  logic               flush_en
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS*TAG_W-1:0] tag0_flat;
    logic [SETS*TAG_W-1:0] tag1_flat;
    logic [SETS-1:0]       valid0_flat;
    logic [SETS-1:0]       valid1_flat;
    logic [SETS-1:0]       lru_flat;

    // Registers rather than RAM: flush must clear every set in one cycle.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        logic [1:0][TAG_W-1:0] tag_reg;
        logic [1:0]            valid_reg;
        logic                  lru_reg;
        logic                  sel;

        assign sel = (idx == INDEX_W'(gi));

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                tag_reg   <= '0;
                valid_reg <= '0;
                lru_reg   <= 1'b0;
            end else if (flush_en) begin
                valid_reg <= '0;
                lru_reg   <= 1'b0;
            end else begin
                if (fill_en && sel) begin
                    tag_reg[fill_way]   <= tag;
                    valid_reg[fill_way] <= 1'b1;
                end
                if (lru_en && sel) begin
                    lru_reg <= lru_val;
                end
            end
        end

        assign tag0_flat[gi*TAG_W +: TAG_W] = tag_reg[0];
        assign tag1_flat[gi*TAG_W +: TAG_W] = tag_reg[1];
        assign valid0_flat[gi]              = valid_reg[0];
        assign valid1_flat[gi]              = valid_reg[1];
        assign lru_flat[gi]                 = lru_reg;
    end

    logic [TAG_W-1:0] rd_tag0;
    logic [TAG_W-1:0] rd_tag1;
    logic             rd_valid0;
    logic             rd_valid1;
    logic             hit0;
    logic             hit1;

    assign rd_tag0   = tag0_flat[int'(idx)*TAG_W +: TAG_W];
    assign rd_tag1   = tag1_flat[int'(idx)*TAG_W +: TAG_W];
    assign rd_valid0 = valid0_flat[idx];
    assign rd_valid1 = valid1_flat[idx];

    assign hit0 = rd_valid0 && (rd_tag0 == tag);
    assign hit1 = rd_valid1 && (rd_tag1 == tag);

    assign hit        = hit0 || hit1;
    assign hit_way    = !hit0;
    assign victim_way = !rd_valid0 ? 1'b0 : (!rd_valid1 ? 1'b1 : lru_flat[idx]);

endmodule

// File: rtl/l2_controller.sv
// L2 tag/state controller: serves L1 read requests, refills from memory on a miss,
// and steers an external data array through way_L2/index_L2_out/refill_L2.
module l2_controller
    import l2_pkg::*;
#(
    parameter int INDEX_W = L2_INDEX_W,
    parameter int TAG_W   = L2_TAG_W
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               read_L1_L2,
    input  logic [INDEX_W-1:0] index_L1_L2,
    input  logic [TAG_W-1:0]   tag_L1_L2,
    input  logic               flush,
    input  logic               ready_MEM_L2,
    output logic               ready_L2_L1,
    output logic               way_L2,
    output logic [INDEX_W-1:0] index_L2_out,
    output logic [TAG_W-1:0]   tag_L2_MEM,
    output logic               read_L2_MEM,
    output logic               refill_L2,
    output logic               L2_miss_o,
    output logic               busy_o
);

    state_t             state_reg;
    state_t             state_next;
    logic [INDEX_W-1:0] req_idx_reg;
    logic [TAG_W-1:0]   req_tag_reg;
    logic               way_reg;
    logic               way_next;

    logic hit;
    logic hit_way;
    logic victim_way;
    logic latch_en;
    logic fill_en;
    logic lru_en;
    logic flush_en;

    l2_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_array (
        .clk        (clk),
        .nrst       (nrst),
        .idx        (req_idx_reg),
        .tag        (req_tag_reg),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .fill_en    (fill_en),
        .fill_way   (way_reg),
        .lru_en     (lru_en),
        .lru_val    (~way_reg),
        .flush_en   (flush_en)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= S_IDLE;
            req_idx_reg <= '0;
            req_tag_reg <= '0;
            way_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            way_reg   <= way_next;
            if (latch_en) begin
                req_idx_reg <= index_L1_L2;
                req_tag_reg <= tag_L1_L2;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        way_next   = way_reg;
        latch_en   = 1'b0;
        flush_en   = 1'b0;
        fill_en    = 1'b0;
        lru_en     = 1'b0;
        L2_miss_o  = 1'b0;
        refill_L2  = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                // Flush takes priority; a concurrent read is picked up next cycle.
                if (flush) begin
                    flush_en = 1'b1;
                end else if (read_L1_L2) begin
                    latch_en   = 1'b1;
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    way_next   = hit_way;
                    state_next = S_RESP;
                end else begin
                    way_next   = victim_way;
                    L2_miss_o  = 1'b1;
                    state_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (ready_MEM_L2) begin
                    refill_L2  = 1'b1;
                    fill_en    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                lru_en     = 1'b1;
                state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Wait for L1 to drop its level request so it cannot re-trigger a lookup.
                if (!read_L1_L2) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ready_L2_L1  = (state_reg == S_RESP);
    assign read_L2_MEM  = (state_reg == S_ALLOCATE);
    assign busy_o       = (state_reg != S_IDLE);
    assign way_L2       = way_reg;
    assign index_L2_out = req_idx_reg;
    assign tag_L2_MEM   = req_tag_reg;

endmodule

// File: tb/tb_l2_controller.sv
// Scoreboard bench for l2_controller: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever ready_L2_L1 is seen.
module tb_l2_controller;
    import l2_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        read_L1_L2 = 1'b0;
    logic [4:0]  index_L1_L2 = '0;
    logic [20:0] tag_L1_L2 = '0;
    logic        flush = 1'b0;
    logic        ready_MEM_L2 = 1'b0;
    logic        ready_L2_L1;
    logic        way_L2;
    logic [4:0]  index_L2_out;
    logic [20:0] tag_L2_MEM;
    logic        read_L2_MEM;
    logic        refill_L2;
    logic        L2_miss_o;
    logic        busy_o;

    always #5 clk = ~clk;

    l2_controller dut (
        .clk          (clk),
        .nrst         (nrst),
        .read_L1_L2   (read_L1_L2),
        .index_L1_L2  (index_L1_L2),
        .tag_L1_L2    (tag_L1_L2),
        .flush        (flush),
        .ready_MEM_L2 (ready_MEM_L2),
        .ready_L2_L1  (ready_L2_L1),
        .way_L2       (way_L2),
        .index_L2_out (index_L2_out),
        .tag_L2_MEM   (tag_L2_MEM),
        .read_L2_MEM  (read_L2_MEM),
        .refill_L2    (refill_L2),
        .L2_miss_o    (L2_miss_o),
        .busy_o       (busy_o)
    );

    typedef struct packed {
        logic       miss;
        logic       way;
        logic [4:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   miss_seen = 1'b0;

    localparam logic [20:0] TAG_A = 21'h1ABCD;
    localparam logic [20:0] TAG_B = 21'h00B0B;
    localparam logic [20:0] TAG_C = 21'h0C0C0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string phase);
        check({phase, "_ready"},  ready_L2_L1, 0);
        check({phase, "_way"},    way_L2, 0);
        check({phase, "_index"},  index_L2_out, 0);
        check({phase, "_memtag"}, tag_L2_MEM, 0);
        check({phase, "_memrd"},  read_L2_MEM, 0);
        check({phase, "_refill"}, refill_L2, 0);
        check({phase, "_miss"},   L2_miss_o, 0);
        check({phase, "_busy"},   busy_o, 0);
    endtask

    // Monitor: compares every response pulse against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                miss_seen = 1'b0;
            end else begin
                if (L2_miss_o) miss_seen = 1'b1;
                if (ready_L2_L1) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_ready: got ready=1 expected no response at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("resp_miss", miss_seen, e.miss);
                        check("resp_way", way_L2, e.way);
                        check("resp_idx", index_L2_out, e.idx);
                    end
                    miss_seen = 1'b0;
                end
            end
        end
    end

    task automatic do_read(input logic [4:0] idx, input logic [20:0] tg, input bit exp_miss,
                           input bit exp_way, input int hold, input bit fl_req, input bit fl_alloc);
        int cyc = 0;
        int mem_cyc = 0;
        int lat;
        bit done = 1'b0;
        exp_t e;
        e.miss = exp_miss;
        e.way  = exp_way;
        e.idx  = idx;
        @(negedge clk);
        read_L1_L2  = 1'b1;
        index_L1_L2 = idx;
        tag_L1_L2   = tg;
        flush       = fl_req;
        sb.push_back(e);
        while (!done) begin
            @(negedge clk);
            cyc++;
            flush        = 1'b0;
            ready_MEM_L2 = 1'b0;
            if (ready_L2_L1) begin
                done = 1'b1;
            end else if (read_L2_MEM) begin
                mem_cyc++;
                check("mem_tag", tag_L2_MEM, tg);
                if (mem_cyc == 4) begin
                    ready_MEM_L2 = 1'b1;
                    #1;
                    check("refill_on_mem", refill_L2, 1);
                end else begin
                    flush = fl_alloc;
                    #1;
                    check("refill_idle", refill_L2, 0);
                end
            end
            if (!done && cyc > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: got no ready after %0d cycles expected a response", cyc);
                done = 1'b1;
            end
        end
        lat = exp_miss ? (fl_req ? 7 : 6) : (fl_req ? 3 : 2);
        check("latency", cyc, lat);
        check("mem_cycles", mem_cyc, exp_miss ? 4 : 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("drain_busy", busy_o, 1);
            check("drain_no_mem", read_L2_MEM, 0);
        end
        read_L1_L2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("back_idle", busy_o, 0);
        $display("txn idx=%0d tag=%06h exp_miss=%0d exp_way=%0d latency=%0d", idx, tg, exp_miss, exp_way, cyc);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        nrst = 1'b1;

        do_read(5'd5,  TAG_A, 1, 0, 0, 0, 0);     // cold miss -> way0
        do_read(5'd5,  TAG_A, 0, 0, 0, 0, 0);     // hit, LRU=1
        do_read(5'd5,  TAG_B, 1, 1, 0, 0, 0);     // fill way1, LRU=0
        do_read(5'd5,  TAG_A, 0, 0, 0, 0, 0);     // hit A, LRU=1
        do_read(5'd5,  TAG_C, 1, 1, 3, 0, 0);     // victim LRU way1; drain held 3 cycles
        do_read(5'd5,  TAG_A, 0, 0, 0, 0, 0);     // A survives in way0, LRU=1
        do_read(5'd5,  TAG_B, 1, 1, 0, 0, 0);     // B evicted earlier -> miss way1
        do_read(5'd31, 21'h1FFFFF, 1, 0, 0, 0, 0); // top set, all-ones tag
        do_read(5'd5,  TAG_A, 1, 0, 0, 1, 1);     // flush with read; flush during allocate ignored
        do_read(5'd5,  TAG_A, 0, 0, 0, 0, 0);     // fill survived the allocate-time flush
        do_read(5'd5,  TAG_B, 1, 1, 0, 0, 0);     // way1 invalid after flush
        do_read(5'd0,  21'h0, 1, 0, 0, 0, 0);     // tag 0 on invalid line must miss

        // Reset in the middle of an allocation.
        @(negedge clk);
        read_L1_L2  = 1'b1;
        index_L1_L2 = 5'd3;
        tag_L1_L2   = 21'h12345;
        for (int i = 0; i < 10 && !read_L2_MEM; i++) @(negedge clk);
        check("pre_reset_alloc", read_L2_MEM, 1);
        nrst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        read_L1_L2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        $display("txn reset asserted during allocate idx=3 tag=012345");

        do_read(5'd3, 21'h12345, 1, 0, 0, 0, 0);  // line was never filled
        do_read(5'd5, TAG_A, 1, 0, 0, 0, 0);      // reset invalidated everything

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l2_controller.md
Name: l2_controller

Overview:
- L2 tag/state controller; the responder on the L1-to-L2 read interface (read_L1_L2, index_L1_L2, tag_L1_L2 in; ready_L2_L1 out).
- 2-way set-associative, 32 sets, per-set LRU bit. Looks up the requested line, fetches it from main memory on a miss, then returns a one-cycle ready pulse to L1.
- Controller only. The data array sits outside the block, steered by refill_L2 and way_L2.

Parameters:
- INDEX_W, 5, set index width (sets = 2**INDEX_W)
- TAG_W, 21, tag width

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- read_L1_L2  in  1  L1 read request, level, held until ready_L2_L1 is seen
- index_L1_L2  in  INDEX_W  requested set
- tag_L1_L2  in  TAG_W  requested tag
- flush  in  1  invalidate all lines (honoured in S_IDLE only)
- ready_MEM_L2  in  1  memory data valid, one-cycle pulse
- ready_L2_L1  out  1  response pulse to L1
- way_L2  out  1  way selected for data-array read/refill
- index_L2_out  out  INDEX_W  latched index to data array and memory
- tag_L2_MEM  out  TAG_W  latched tag to memory
- read_L2_MEM  out  1  memory read request, level
- refill_L2  out  1  data-array write enable
- L2_miss_o  out  1  one-cycle miss indication
- busy_o  out  1  state != S_IDLE

Behaviour:
- Clock and reset: single clock, clk. nrst is asynchronous, active-low.
- Reset values: state S_IDLE; all valid bits 0; LRU 0; tags 0; latched req 0; all outputs 0.
- Reset mid-operation aborts any transaction with no tag or valid update.
- States: S_IDLE, S_LOOKUP, S_ALLOCATE, S_RESP, S_DRAIN.
- S_IDLE:
  - flush=1: clear all valid and LRU bits; stay in S_IDLE. Flush wins over a simultaneous read; the read is served on the next cycle.
  - Otherwise read_L1_L2=1: latch index/tag into req_idx/req_tag; go to S_LOOKUP.
- S_LOOKUP (exactly 1 cycle):
  - Hit = (valid[w] && TAG[idx][w]==req_tag) for w=0 or w=1. Way 0 is checked first; both matching is impossible by construction.
  - On hit: way_L2 <= hit way; go to S_RESP.
  - On miss:
    - victim = way 0 if invalid, else way 1 if invalid, else LRU[idx].
    - way_L2 <= victim; L2_miss_o=1 in this cycle (combinational from state and compare); go to S_ALLOCATE.
- S_ALLOCATE:
  - read_L2_MEM=1; tag_L2_MEM=req_tag.
  - On ready_MEM_L2=1, in the same cycle: refill_L2=1 (combinational); TAG[idx][way] <= req_tag; valid <= 1; go to S_RESP.
  - Otherwise wait with no timeout.
- S_RESP (exactly 1 cycle):
  - ready_L2_L1=1; way_L2 and index_L2_out stable.
  - LRU[idx] <= ~way_L2, on both hit and fill.
  - Go to S_DRAIN.
- S_DRAIN: return to S_IDLE when read_L1_L2=0. This stops a lingering registered request from L1 re-triggering a lookup.
- Output timing:
  - ready_L2_L1, read_L2_MEM and busy_o are decoded from the state register.
  - way_L2 and index_L2_out are registers.
  - L2_miss_o and refill_L2 are combinational.
- Latency:
  - Hit: request sampled at edge k; ready_L2_L1 high in the cycle after edge k+1.
  - Miss: ready_L2_L1 high in the cycle after the edge that samples ready_MEM_L2.
- Input stability: index/tag changes after latching are ignored.
- Ignored inputs: flush outside S_IDLE; ready_MEM_L2 outside S_ALLOCATE.

Decomposition:
- Shared package l2_pkg holds:
  - state encoding: S_IDLE=3'b000, S_LOOKUP=3'b001, S_ALLOCATE=3'b011, S_RESP=3'b010, S_DRAIN=3'b110
  - L2_INDEX_W=5 and L2_TAG_W=21 constants
- One sub-module, l2_tag_array: tag, valid and LRU storage. It provides a combinational two-way compare and the victim select, plus write ports for fill, LRU and flush.

Test Plan:
- Cold miss: reset; read idx=5 tag=0x1ABCD.
  - Required: L2_miss_o pulses; read_L2_MEM=1 with tag_L2_MEM=0x1ABCD, way_L2=0.
  - Required: ready_MEM_L2 after 4 cycles gives refill_L2=1 in that cycle, then ready_L2_L1 for exactly 1 cycle.
- Hit latency: repeat read idx=5 tag=0x1ABCD.
  - Required: no read_L2_MEM; ready_L2_L1 two cycles after sampling; way_L2=0.
- LRU replacement, all in idx=5:
  - fill tag A -> way0;
  - fill tag B -> way1;
  - hit A (LRU -> 1);
  - read tag C -> victim way1, A still hits way0, B misses.
- Drain: hold read_L1_L2 high 3 cycles past ready.
  - Required: exactly one ready pulse; no second lookup; busy_o=1 until read_L1_L2 drops.
- Flush: flush in S_IDLE together with read.
  - Required: read is served next cycle and misses.
  - Required: flush asserted during S_ALLOCATE does not clear the fill.
- Reset mid-ALLOCATE: nrst low.
  - Required: all outputs 0 immediately; the set stays invalid; the next identical read misses.
